// File: rtl/fetch_alu_bus_pkg.sv
// Shared types and constants for the fetch/ALU/bus slice.
package fetch_alu_bus_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 6;

  typedef enum logic [1:0] {
    CW_BYTE    = 2'd0,
    CW_WORD    = 2'd1,
    CW_LONG    = 2'd2,
    CW_ILLEGAL = 2'd3
  } t_cycle_width;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDC = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBC = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOT  = 4'd7,
    ALU_COPY = 4'd8,
    ALU_LSL  = 4'd9,
    ALU_LSR  = 4'd10,
    ALU_ASR  = 4'd11
  } t_alu_op;

  localparam logic [OPC_W-1:0] OPC_NOP       = 6'h00;
  localparam logic [OPC_W-1:0] OPC_HALT      = 6'h01;
  localparam logic [1:0]       OPC_MEM_CLASS = 2'b01;
  localparam logic [XLEN-1:0]  INSTR_NOP     = 32'h0000_0000;

  // Opcode field of an instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[31:26];
  endfunction

  // Memory-class instructions carry 2'b01 in the top opcode bits.
  function automatic logic is_mem_op(input logic [XLEN-1:0] instr);
    return instr[31:30] == OPC_MEM_CLASS;
  endfunction

endpackage

// File: rtl/fetch_alu_bus_alu_unit.sv
// Combinational ALU: arithmetic, logic and shifts with carry/zero/neg/overflow flags.
module alu_unit
  import fetch_alu_bus_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] reg2,
  input  logic [XLEN-1:0] reg3,
  input  logic            carry_in,
  output logic [XLEN-1:0] result,
  output logic            carry_out,
  output logic            zero_out,
  output logic            neg_out,
  output logic            over_out
);

  logic [XLEN:0]   wide;
  logic [4:0]      shamt;
  logic [XLEN-1:0] res;
  logic            cout;
  logic            ovf;

  // Operation select; borrow is bit 32 of the 33-bit difference.
  always_comb begin
    wide  = '0;
    res   = reg2;
    cout  = 1'b0;
    ovf   = 1'b0;
    shamt = reg3[4:0];
    case (op)
      ALU_ADD, ALU_ADDC: begin
        wide = {1'b0, reg2} + {1'b0, reg3}
             + {32'b0, (op == ALU_ADDC) & carry_in};
        res  = wide[31:0];
        cout = wide[32];
        ovf  = (reg2[31] == reg3[31]) && (res[31] != reg2[31]);
      end
      ALU_SUB, ALU_SUBC: begin
        wide = {1'b0, reg2} - {1'b0, reg3}
             - {32'b0, (op == ALU_SUBC) & carry_in};
        res  = wide[31:0];
        cout = wide[32];
        ovf  = (reg2[31] != reg3[31]) && (res[31] != reg2[31]);
      end
      ALU_AND:  res = reg2 & reg3;
      ALU_OR:   res = reg2 | reg3;
      ALU_XOR:  res = reg2 ^ reg3;
      ALU_NOT:  res = ~reg3;
      ALU_COPY: res = reg3;
      ALU_LSL: begin
        wide = {1'b0, reg2} << shamt;
        res  = wide[31:0];
        cout = (shamt == 5'd0) ? carry_in : wide[32];
      end
      ALU_LSR: begin
        wide = {reg2, 1'b0} >> shamt;
        res  = wide[32:1];
        cout = (shamt == 5'd0) ? carry_in : wide[0];
      end
      ALU_ASR: begin
        wide = 33'($signed({reg2, 1'b0}) >>> shamt);
        res  = wide[32:1];
        cout = (shamt == 5'd0) ? carry_in : wide[0];
      end
      default: res = reg2;
    endcase
  end

  assign result    = res;
  assign carry_out = cout;
  assign over_out  = ovf;
  assign zero_out  = (res == '0);
  assign neg_out   = res[31];

endmodule

// File: rtl/fetch_alu_bus.sv
// Instruction fetch sequencer with memory-op bubbles, halt countdown, and big-endian bus steering.
module fetch_alu_bus
  import fetch_alu_bus_pkg::*;
#(
  parameter int unsigned HALT_DELAY = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_reg2,
  input  logic [XLEN-1:0] alu_reg3,
  input  logic            alu_carry_in,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_carry_out,
  output logic            alu_zero_out,
  output logic            alu_neg_out,
  output logic            alu_over_out,
  input  logic            mem_read,
  input  logic            mem_write,
  input  t_cycle_width    mem_cycle_width,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] instruction,
  output logic            block_fetch,
  output logic            halting,
  output logic            halted,
  output logic            pc_inc,
  output logic [XLEN-1:0] load_data,
  output logic [29:0]     address,
  input  logic [XLEN-1:0] data_in,
  output logic [XLEN-1:0] data_out,
  output logic [3:0]      data_strobes,
  output logic            read,
  output logic            write,
  output logic            bus_error
);

  localparam int unsigned CNT_W = $clog2(HALT_DELAY + 1) + 1;

  alu_unit u_alu (
    .op        (alu_op),
    .reg2      (alu_reg2),
    .reg3      (alu_reg3),
    .carry_in  (alu_carry_in),
    .result    (alu_result),
    .carry_out (alu_carry_out),
    .zero_out  (alu_zero_out),
    .neg_out   (alu_neg_out),
    .over_out  (alu_over_out)
  );

  logic [XLEN-1:0]  instruction_q, instruction_d;
  logic             block_fetch_q, block_fetch_d;
  logic             halting_q, halting_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] halt_cnt_q, halt_cnt_d;

  // Next fetch state: bubble or halt loads NOP, otherwise capture the bus word.
  always_comb begin
    instruction_d = INSTR_NOP;
    block_fetch_d = 1'b0;
    halting_d     = halting_q;
    halted_d      = halted_q;
    halt_cnt_d    = halt_cnt_q;
    if (!block_fetch_q && !halting_q) begin
      instruction_d = data_in;
      block_fetch_d = is_mem_op(data_in);
      halting_d     = (opcode_of(data_in) == OPC_HALT);
    end
    if (halting_q && !halted_q) begin
      halt_cnt_d = halt_cnt_q + CNT_W'(1);
      halted_d   = (halt_cnt_q == CNT_W'(HALT_DELAY));
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction_q <= INSTR_NOP;
      block_fetch_q <= 1'b0;
      halting_q     <= 1'b0;
      halted_q      <= 1'b0;
      halt_cnt_q    <= '0;
    end else begin
      instruction_q <= instruction_d;
      block_fetch_q <= block_fetch_d;
      halting_q     <= halting_d;
      halted_q      <= halted_d;
      halt_cnt_q    <= halt_cnt_d;
    end
  end

  assign instruction = instruction_q;
  assign block_fetch = block_fetch_q;
  assign halting     = halting_q;
  assign halted      = halted_q;
  assign pc_inc      = !block_fetch_q && !halting_q;

  logic [XLEN-1:0] cpu_addr;
  logic [XLEN-1:0] cpu_wdata;
  logic            cpu_rd;
  logic            cpu_wr;
  t_cycle_width    cpu_cw;
  logic [1:0]      ofs;
  logic [4:0]      lane_sh;
  logic            err;
  logic [3:0]      strb;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;

  // Cycle mux: fetch cycles read a long at pc, bubbles run the CPU memory op.
  always_comb begin
    cpu_addr  = pc;
    cpu_wdata = '0;
    cpu_rd    = 1'b1;
    cpu_wr    = 1'b0;
    cpu_cw    = CW_LONG;
    if (block_fetch_q) begin
      cpu_addr  = alu_result;
      cpu_wdata = store_data;
      cpu_rd    = mem_read;
      cpu_wr    = mem_write;
      cpu_cw    = mem_cycle_width;
    end
  end

  // Big-endian lane steering; misaligned or illegal widths kill the cycle.
  always_comb begin
    ofs     = cpu_addr[1:0];
    lane_sh = {~ofs, 3'b000};
    err     = 1'b0;
    strb    = 4'b0000;
    wdata   = cpu_wdata;
    rdata   = '0;
    case (cpu_cw)
      CW_BYTE: begin
        strb  = 4'b1000 >> ofs;
        wdata = {4{cpu_wdata[7:0]}};
        rdata = {24'b0, 8'(data_in >> lane_sh)};
      end
      CW_WORD: begin
        err   = ofs[0];
        strb  = ofs[1] ? 4'b0011 : 4'b1100;
        wdata = {2{cpu_wdata[15:0]}};
        rdata = {16'b0, ofs[1] ? data_in[15:0] : data_in[31:16]};
      end
      CW_LONG: begin
        err   = (ofs != 2'b00);
        strb  = 4'b1111;
        rdata = data_in;
      end
      default: err = 1'b1;
    endcase
    if (err) begin
      strb  = 4'b0000;
      rdata = '0;
    end
  end

  assign address      = cpu_addr[31:2];
  assign data_out     = wdata;
  assign load_data    = rdata;
  assign data_strobes = strb;
  assign read         = cpu_rd && !err;
  assign write        = cpu_wr && !err;
  assign bus_error    = err;

endmodule

// File: tb/tb_fetch_alu_bus.sv
// Scoreboard bench for fetch_alu_bus: ALU vectors, fetch/bubble/halt sequencing, bus steering.
module tb_fetch_alu_bus;
  import fetch_alu_bus_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  pc = '0;
  logic [3:0]   alu_op = '0;
  logic [31:0]  alu_reg2 = '0, alu_reg3 = '0;
  logic         alu_carry_in = 1'b0;
  logic [31:0]  alu_result;
  logic         alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out;
  logic         mem_read = 1'b0, mem_write = 1'b0;
  t_cycle_width mem_cycle_width = CW_LONG;
  logic [31:0]  store_data = '0;
  logic [31:0]  instruction, load_data, data_in = '0, data_out;
  logic         block_fetch, halting, halted, pc_inc;
  logic [29:0]  address;
  logic [3:0]   data_strobes;
  logic         read, write, bus_error;

  int total = 0;
  int bad   = 0;

  fetch_alu_bus #(.HALT_DELAY(3)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .alu_op(alu_op), .alu_reg2(alu_reg2), .alu_reg3(alu_reg3), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_zero_out(alu_zero_out),
    .alu_neg_out(alu_neg_out), .alu_over_out(alu_over_out),
    .mem_read(mem_read), .mem_write(mem_write), .mem_cycle_width(mem_cycle_width),
    .store_data(store_data), .instruction(instruction), .block_fetch(block_fetch),
    .halting(halting), .halted(halted), .pc_inc(pc_inc), .load_data(load_data),
    .address(address), .data_in(data_in), .data_out(data_out), .data_strobes(data_strobes),
    .read(read), .write(write), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboards ----------------
  typedef struct {logic [31:0] res; logic [3:0] flags;} alu_exp_t;
  typedef struct {logic [31:0] instr; logic bf; logic hing; logic hed;} st_exp_t;
  typedef struct {
    logic [29:0] addr; logic [3:0] strb; logic [31:0] dout; logic [31:0] load;
    logic rd; logic wr; logic err;
  } bus_exp_t;

  alu_exp_t alu_q[$];
  st_exp_t  st_q[$];
  bus_exp_t bus_q[$];

  task automatic sb_underflow(input string tag);
    total++;
    bad++;
    $display("FAIL %s: scoreboard empty", tag);
  endtask

  task automatic pop_alu(input string tag);
    alu_exp_t e;
    if (alu_q.size() == 0) begin sb_underflow(tag); return; end
    e = alu_q.pop_front();
    check({tag, "_res"}, alu_result, e.res);
    check({tag, "_czno"}, {28'b0, alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out},
          {28'b0, e.flags});
  endtask

  task automatic push_state(input logic [31:0] instr, input logic bf, input logic hing,
                            input logic hed);
    st_exp_t e;
    e.instr = instr; e.bf = bf; e.hing = hing; e.hed = hed;
    st_q.push_back(e);
  endtask

  task automatic pop_state(input string tag);
    st_exp_t e;
    if (st_q.size() == 0) begin sb_underflow(tag); return; end
    e = st_q.pop_front();
    check({tag, "_instr"}, instruction, e.instr);
    check({tag, "_bf_hing_hed_pcinc"}, {28'b0, block_fetch, halting, halted, pc_inc},
          {28'b0, e.bf, e.hing, e.hed, !e.bf && !e.hing});
  endtask

  task automatic push_bus(input logic [29:0] addr, input logic [3:0] strb, input logic [31:0] dout,
                          input logic [31:0] load, input logic rd, input logic wr, input logic err);
    bus_exp_t e;
    e.addr = addr; e.strb = strb; e.dout = dout; e.load = load;
    e.rd = rd; e.wr = wr; e.err = err;
    bus_q.push_back(e);
  endtask

  task automatic pop_bus(input string tag);
    bus_exp_t e;
    if (bus_q.size() == 0) begin sb_underflow(tag); return; end
    e = bus_q.pop_front();
    check({tag, "_addr"}, {2'b0, address}, {2'b0, e.addr});
    check({tag, "_strb_rd_wr_err"}, {25'b0, data_strobes, read, write, bus_error},
          {25'b0, e.strb, e.rd, e.wr, e.err});
    if (!e.err) begin
      check({tag, "_dout"}, data_out, e.dout);
      check({tag, "_load"}, load_data, e.load);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    logic [3:0] op; logic [31:0] a; logic [31:0] b; logic cin;
    logic [31:0] res; logic [3:0] flags;  // {carry, zero, neg, over}
  } alu_vec_t;

  localparam int N_ALU = 16;
  alu_vec_t alu_tab [N_ALU] = '{
    '{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0011},
    '{ALU_SUB,  32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 4'b0100},
    '{ALU_SUB,  32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 4'b1010},
    '{ALU_ADDC, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b1100},
    '{ALU_SUBC, 32'h0000_0010, 32'h0000_0003, 1'b1, 32'h0000_000C, 4'b0000},
    '{ALU_SUB,  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0001},
    '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 4'b0010},
    '{ALU_OR,   32'h0000_000F, 32'h0000_00F0, 1'b0, 32'h0000_00FF, 4'b0000},
    '{ALU_XOR,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b0, 32'h5555_5555, 4'b0000},
    '{ALU_NOT,  32'h1234_5678, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 4'b0010},
    '{ALU_COPY, 32'h0000_0000, 32'h1234_5678, 1'b1, 32'h1234_5678, 4'b0000},
    '{ALU_LSL,  32'h8000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 4'b1000},
    '{ALU_LSR,  32'h0000_0003, 32'h0000_0001, 1'b0, 32'h0000_0001, 4'b1000},
    '{ALU_ASR,  32'h8000_0000, 32'h0000_0004, 1'b1, 32'hF800_0000, 4'b0010},
    '{ALU_LSL,  32'h0000_0005, 32'h0000_0020, 1'b1, 32'h0000_0005, 4'b1000},
    '{4'd12,    32'h0000_DEAD, 32'h0000_BEEF, 1'b1, 32'h0000_DEAD, 4'b0000}
  };

  typedef struct {
    logic [31:0] ea; t_cycle_width cw; logic rd; logic wr; logic [31:0] sdata; logic [31:0] din;
    logic [29:0] addr; logic [3:0] strb; logic [31:0] dout; logic [31:0] load;
    logic erd; logic ewr; logic err;
  } bub_vec_t;

  localparam int N_BUB = 8;
  bub_vec_t bub_tab [N_BUB] = '{
    '{32'h1002, CW_WORD, 1'b0, 1'b1, 32'h0000_ABCD, 32'h0,
      30'h400, 4'b0011, 32'hABCD_ABCD, 32'h0, 1'b0, 1'b1, 1'b0},
    '{32'h2001, CW_BYTE, 1'b1, 1'b0, 32'h0000_005A, 32'h1122_3344,
      30'h800, 4'b0100, 32'h5A5A_5A5A, 32'h22, 1'b1, 1'b0, 1'b0},
    '{32'h1001, CW_LONG, 1'b1, 1'b0, 32'h0, 32'h0,
      30'h400, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1},
    '{32'h3000, CW_ILLEGAL, 1'b0, 1'b1, 32'h0, 32'h0,
      30'hC00, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1},
    '{32'h1000, CW_WORD, 1'b1, 1'b0, 32'h1234_5678, 32'hCAFE_BEEF,
      30'h400, 4'b1100, 32'h5678_5678, 32'h0000_CAFE, 1'b1, 1'b0, 1'b0},
    '{32'h1003, CW_WORD, 1'b0, 1'b1, 32'h0, 32'h0,
      30'h400, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1},
    '{32'h2003, CW_BYTE, 1'b0, 1'b1, 32'h0000_01FF, 32'h0000_00EE,
      30'h800, 4'b0001, 32'hFFFF_FFFF, 32'h0000_00EE, 1'b0, 1'b1, 1'b0},
    '{32'h4004, CW_LONG, 1'b0, 1'b1, 32'h8765_4321, 32'h1357_9BDF,
      30'h1001, 4'b1111, 32'h8765_4321, 32'h1357_9BDF, 1'b0, 1'b1, 1'b0}
  };

  // ---------------- test sequence ----------------
  initial begin
    // Reset state, checked before any clock edge.
    #3;
    push_state(32'h0, 1'b0, 1'b0, 1'b0);
    pop_state("reset");

    // ALU vectors (combinational).
    for (int i = 0; i < N_ALU; i++) begin
      alu_op = alu_tab[i].op; alu_reg2 = alu_tab[i].a;
      alu_reg3 = alu_tab[i].b; alu_carry_in = alu_tab[i].cin;
      alu_q.push_back('{alu_tab[i].res, alu_tab[i].flags});
      #1;
      pop_alu($sformatf("alu%0d", i));
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Fetch cycle bus view; CPU write request must be ignored.
    pc = 32'h0000_1000; data_in = 32'h0000_0000; mem_write = 1'b1; store_data = 32'hFFFF_FFFF;
    push_bus(30'h400, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    pop_bus("fetch_bus");
    pc = 32'h0000_0FFE;
    push_bus(30'h3FF, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    pop_bus("fetch_misalign");
    pc = 32'h0000_1000;

    // Memory ops back to back: fetch, bubble with CPU access, NOP reload.
    alu_op = ALU_COPY;
    for (int i = 0; i < N_BUB; i++) begin
      data_in = 32'h4000_0000 | 32'(i);
      push_state(32'h4000_0000 | 32'(i), 1'b1, 1'b0, 1'b0);
      step();
      pop_state($sformatf("memop%0d", i));
      alu_reg3 = bub_tab[i].ea; mem_cycle_width = bub_tab[i].cw;
      mem_read = bub_tab[i].rd; mem_write = bub_tab[i].wr;
      store_data = bub_tab[i].sdata; data_in = bub_tab[i].din;
      push_bus(bub_tab[i].addr, bub_tab[i].strb, bub_tab[i].dout, bub_tab[i].load,
               bub_tab[i].erd, bub_tab[i].ewr, bub_tab[i].err);
      #1;
      pop_bus($sformatf("bubble%0d", i));
      push_state(32'h0, 1'b0, 1'b0, 1'b0);
      step();
      pop_state($sformatf("nop%0d", i));
    end

    // HALT capture and countdown; later fetch words are ignored.
    data_in = 32'h0400_0000;
    push_state(32'h0400_0000, 1'b0, 1'b1, 1'b0);
    step();
    pop_state("halt_capture");
    data_in = 32'h4000_0000;
    for (int i = 1; i <= 5; i++) begin
      push_state(32'h0, 1'b0, 1'b1, i >= 4);
      step();
      pop_state($sformatf("halt_clk%0d", i));
    end

    // Asynchronous reset mid-halt.
    #2 rst_n = 1'b0;
    #1;
    push_state(32'h0, 1'b0, 1'b0, 1'b0);
    pop_state("reset_halt");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-bubble, then first cycle after release is a fetch.
    data_in = 32'h4000_0000;
    push_state(32'h4000_0000, 1'b1, 1'b0, 1'b0);
    step();
    pop_state("memop_pre_reset");
    #2 rst_n = 1'b0;
    #1;
    push_state(32'h0, 1'b0, 1'b0, 1'b0);
    pop_state("reset_bubble");
    @(negedge clk);
    rst_n = 1'b1;
    data_in = 32'hAAAA_0000;
    push_state(32'hAAAA_0000, 1'b0, 1'b0, 1'b0);
    step();
    pop_state("fetch_after_reset");

    if (alu_q.size() + st_q.size() + bus_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: %0d entries left, 0 expected",
               alu_q.size() + st_q.size() + bus_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_alu_bus.md
FETCH_ALU_BUS -- requirements
Module: fetch_alu_bus

Interface
REQ-001 Parameter HALT_DELAY, default 3: clocks between `halting` and `halted`.
REQ-002 clock  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 pc  in  32  program counter (fetch address).
REQ-005 alu_op  in  4  ALU operation; alu_reg2, alu_reg3  in  32 each; alu_carry_in  in  1.
REQ-006 alu_result  out  32; alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out  out  1 each.
REQ-007 mem_read, mem_write  in  1 each; mem_cycle_width  in  2 (t_cycle_width); store_data  in  32.
REQ-008 instruction  out  32; block_fetch, halting, halted, pc_inc  out  1 each; load_data  out  32.
REQ-009 address  out  30 ([31:2]); data_in  in  32; data_out  out  32; data_strobes  out  4; read, write, bus_error  out  1 each.

Function
REQ-010 t_cycle_width SHALL be CW_BYTE=0, CW_WORD=1, CW_LONG=2; 3 is illegal and SHALL raise bus_error.
REQ-011 Bus side combinational; big-endian lanes, byte offset a=cpu_address[1:0], address=cpu_address[31:2].
REQ-012 Byte: strobe 1000>>a, store byte replicated on all lanes, load zero-extended into [7:0].
REQ-013 Word: a=0 -> 1100 (lane [31:16]), a=2 -> 0011; store halfword replicated; load zero-extended; a odd -> bus_error.
REQ-014 Long: a=0 -> 1111, passthrough; a!=0 -> bus_error.
REQ-015 On bus_error: data_strobes=0000, read=0, write=0.
REQ-016 Cycle mux: block_fetch=0 -> cpu_address=pc, read=1, write=0, CW_LONG, data_out=0; block_fetch=1 -> cpu_address=alu_result, mem_read/mem_write/mem_cycle_width/store_data.
REQ-017 pc_inc = !block_fetch && !halting.
REQ-018 ALU combinational, ops: 0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 AND, 5 OR, 6 XOR, 7 NOT(~reg3), 8 COPY(reg3), 9 LSL, 10 LSR, 11 ASR; 12-15 reserved, result=reg2.
REQ-019 SUB/SUBC compute reg2-reg3(-carry_in); carry_out=borrow; ADD/ADDC carry_out=bit 32 of 33-bit sum.
REQ-020 over_out = signed overflow for add/sub ops, else 0.
REQ-021 Shifts shift reg2 by reg3[4:0]; carry_out=last bit shifted out, =carry_in when amount 0.
REQ-022 Logic/COPY/NOT/reserved: carry_out=0; all ops: zero_out=(result==0), neg_out=result[31].
REQ-023 Opcode=instr[31:26]; NOP=6'h00, HALT=6'h01, memory ops opcode[5:4]=2'b01.
REQ-024 Fetch: each edge with block_fetch=0 and halting=0, instruction <= data_in (full long).
REQ-025 Capturing a memory op sets block_fetch=1 for exactly the next cycle (memory op on instruction); next edge loads NOP, clears block_fetch.
REQ-026 Capturing HALT sets halting (sticky until reset); subsequent edges load NOP.
REQ-027 Counter counts clocks with halting=1; halted asserts after HALT_DELAY+1 such clocks, sticky.
REQ-028 Back-to-back memory ops: each gets its own bubble; HALT never captured during block_fetch cycle.

Reset
REQ-029 Reset asserted: instruction=NOP, block_fetch=0, halting=0, halted=0, counter=0, immediately and regardless of clock.
REQ-030 Reset mid-memory-cycle or mid-halt aborts it; first cycle after release is a fetch.

Structure
REQ-031 t_cycle_width, t_alu_op, opcode constants, NOP value in shared package.
REQ-032 ALU as sub-module alu_unit; fetch and bus logic in top.

Verification
REQ-033 ADD 0x7FFFFFFF+1 -> 0x80000000, over=1, neg=1, carry=0; SUB 5-5 -> 0, zero=1, carry=0; SUB 3-5 -> carry=1.
REQ-034 block_fetch=1, alu_result=0x1002, CW_WORD, write, store_data=0xABCD -> address=0x400, strobes 0011, data_out=0xABCDABCD.
REQ-035 Long access at 0x1001 -> bus_error=1, strobes 0000, read=0.
REQ-036 Fetch 0x40000000 (memory op) -> next cycle block_fetch=1, pc_inc=0; then instruction=0, block_fetch=0.
REQ-037 Fetch 0x04000000 (HALT) -> halting=1, pc_inc=0, halted=1 after 4 clocks; reset low clears all.
